// File: rtl/demux_stream_1x4.sv
// Registered 1-to-4 stream demultiplexer with unicast/broadcast steering,
// per-channel holding registers and per-channel transfer counters.
module demux_stream_1x4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              bcast,
  output logic [DATA_W-1:0] y0_data,
  output logic [DATA_W-1:0] y1_data,
  output logic [DATA_W-1:0] y2_data,
  output logic [DATA_W-1:0] y3_data,
  output logic [3:0]        y_valid,
  input  logic [3:0]        y_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
);

  // Handshake: a word moves on any interface exactly in a cycle where its
  // valid and ready are both high at the rising edge; in_ready never looks
  // at in_valid, and a channel may drain and reload at the same edge.

  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic [CNT_W-1:0]  cnt_q  [4];
  logic [CNT_W-1:0]  cnt_d  [4];
  logic [3:0]        valid_q;
  logic [3:0]        valid_d;
  logic [3:0]        can_load;
  logic [3:0]        load;
  logic [3:0]        xfer;
  logic              accept;

  always_comb begin
    can_load = ~valid_q | y_ready;
    // Broadcast is all-or-nothing so no channel ever receives a partial copy.
    in_ready = bcast ? (&can_load) : can_load[in_sel];
    accept   = in_valid & in_ready;
    xfer     = valid_q & y_ready;
    load     = 4'b0000;
    if (accept) begin
      if (bcast) load = 4'b1111;
      else       load[in_sel] = 1'b1;
    end
    valid_d = load | (valid_q & ~y_ready);
    for (int k = 0; k < 4; k++) begin
      data_d[k] = load[k] ? in_data : data_q[k];
      cnt_d[k]  = xfer[k] ? (cnt_q[k] + CNT_W'(1)) : cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign y_valid = valid_q;
  assign y0_data = data_q[0];
  assign y1_data = data_q[1];
  assign y2_data = data_q[2];
  assign y3_data = data_q[3];
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];
  assign cnt3    = cnt_q[3];

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Directed bench for demux_stream_1x4: unicast, backpressure, streaming,
// broadcast, asynchronous reset and counter wrap.
module tb_demux_stream_1x4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       bcast;
  logic [7:0] y0_data, y1_data, y2_data, y3_data;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int checks;
  int errors;

  demux_stream_1x4 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .bcast    (bcast),
    .y0_data  (y0_data),
    .y1_data  (y1_data),
    .y2_data  (y2_data),
    .y3_data  (y3_data),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic b);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    bcast    = b;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    y_ready  = 4'b0000;
    drive(1'b0, 8'h00, 2'd0, 1'b0);

    // Reset state
    #2;
    check("rst_valid", 32'(y_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_y0", 32'(y0_data), 32'h0);
    check("rst_y3", 32'(y3_data), 32'h0);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);

    // Unicast A5 to channel 2
    y_ready = 4'b1111;
    drive(1'b1, 8'hA5, 2'd2, 1'b0);
    #1;
    check("uni_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("uni_y2", 32'(y2_data), 32'hA5);
    check("uni_valid", 32'(y_valid), 32'h4);
    check("uni_cnt2_pre", 32'(cnt2), 32'h0);
    step();
    check("uni_cnt2", 32'(cnt2), 32'h1);
    check("uni_valid_drained", 32'(y_valid), 32'h0);
    check("uni_y2_retained", 32'(y2_data), 32'hA5);

    // Backpressure on channel 1
    y_ready = 4'b0000;
    drive(1'b1, 8'h11, 2'd1, 1'b0);
    step();
    check("bp_y1", 32'(y1_data), 32'h11);
    check("bp_valid1", 32'(y_valid), 32'h2);
    drive(1'b1, 8'h22, 2'd1, 1'b0);
    #1;
    check("bp_ready_blocked", 32'(in_ready), 32'h0);
    step();
    check("bp_y1_held", 32'(y1_data), 32'h11);
    check("bp_valid_held", 32'(y_valid), 32'h2);
    drive(1'b1, 8'h33, 2'd0, 1'b0);
    #1;
    check("bp_ready_ch0", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("bp_y0", 32'(y0_data), 32'h33);
    check("bp_y1_still", 32'(y1_data), 32'h11);
    check("bp_valid_both", 32'(y_valid), 32'h3);
    y_ready = 4'b1111;
    step();
    check("bp_drain_valid", 32'(y_valid), 32'h0);
    check("bp_cnt0", 32'(cnt0), 32'h1);
    check("bp_cnt1", 32'(cnt1), 32'h1);
    check("bp_cnt2", 32'(cnt2), 32'h1);

    // Streaming four words to channel 3
    y_ready = 4'b1000;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 2'd3, 1'b0);
      #1;
      check("str_ready", 32'(in_ready), 32'h1);
      step();
      check("str_y3", 32'(y3_data), 32'(i));
      check("str_valid", 32'(y_valid), 32'h8);
      check("str_cnt3_run", 32'(cnt3), 32'(i - 1));
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    check("str_cnt3", 32'(cnt3), 32'h4);
    check("str_valid_end", 32'(y_valid), 32'h0);

    // Broadcast into empty channels
    y_ready = 4'b0000;
    drive(1'b1, 8'h5A, 2'd1, 1'b1);
    #1;
    check("bc_ready", 32'(in_ready), 32'h1);
    step();
    check("bc_valid", 32'(y_valid), 32'hF);
    check("bc_y0", 32'(y0_data), 32'h5A);
    check("bc_y1", 32'(y1_data), 32'h5A);
    check("bc_y2", 32'(y2_data), 32'h5A);
    check("bc_y3", 32'(y3_data), 32'h5A);

    // Broadcast blocked by full, stalled channel 2
    y_ready = 4'b1011;
    drive(1'b1, 8'hC3, 2'd0, 1'b1);
    #1;
    check("bc_blocked", 32'(in_ready), 32'h0);
    step();
    check("bc_blk_y0", 32'(y0_data), 32'h5A);
    check("bc_blk_y2", 32'(y2_data), 32'h5A);
    check("bc_blk_valid", 32'(y_valid), 32'h4);
    check("bc_blk_ready", 32'(in_ready), 32'h0);
    check("bc_cnt0", 32'(cnt0), 32'h2);
    check("bc_cnt1", 32'(cnt1), 32'h2);
    check("bc_cnt3", 32'(cnt3), 32'h5);
    check("bc_cnt2_hold", 32'(cnt2), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    y_ready = 4'b1111;
    step();
    check("bc_cnt2", 32'(cnt2), 32'h2);
    check("bc_valid_end", 32'(y_valid), 32'h0);

    // Asynchronous reset with channels 1 and 2 full
    y_ready = 4'b0000;
    drive(1'b1, 8'h77, 2'd1, 1'b0);
    step();
    drive(1'b1, 8'h88, 2'd2, 1'b0);
    step();
    drive(1'b0, 8'h00, 2'd1, 1'b0);
    check("ar_valid_pre", 32'(y_valid), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(y_valid), 32'h0);
    check("ar_y1", 32'(y1_data), 32'h0);
    check("ar_y2", 32'(y2_data), 32'h0);
    check("ar_cnt3", 32'(cnt3), 32'h0);
    check("ar_ready", 32'(in_ready), 32'h1);
    #1;
    rst_n = 1'b1;
    step();
    check("ar_valid_after", 32'(y_valid), 32'h0);
    check("ar_cnt0_after", 32'(cnt0), 32'h0);

    // Counter wrap: 256 transfers on channel 0
    y_ready = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 2'd0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("wrap_cnt0_255", 32'(cnt0), 32'hFF);
    check("wrap_y0_last", 32'(y0_data), 32'hFF);
    step();
    check("wrap_cnt0", 32'(cnt0), 32'h0);
    check("wrap_valid", 32'(y_valid), 32'h0);
    check("wrap_cnt1_quiet", 32'(cnt1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_1x4.md
# demux_stream_1x4

Registered 1-to-4 stream demultiplexer with valid/ready handshakes on the input and on each of four output channels. It sits directly upstream of consumers that previously received raw combinational demux outputs: it accepts one word per cycle, steers it to the channel selected by `in_sel` (or to all four when `bcast` is high), and holds it in a per-channel output register until that channel's consumer takes it. Per-channel transfer counters give the bench and debug logic visibility of traffic per output.

## Interface
- `DATA_W`, 8, width of the data word.
- `CNT_W`, 8, width of each per-channel transfer counter.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  block accepts the word this cycle.
- `in_data`  input  DATA_W  upstream word.
- `in_sel`  input  2  destination channel 0..3; ignored when `bcast`=1.
- `bcast`  input  1  deliver the word to all four channels.
- `y0_data`..`y3_data`  output  DATA_W each  channel output registers.
- `y_valid`  output  4  bit k: channel k holds a word.
- `y_ready`  input  4  bit k: channel k consumer accepts this cycle.
- `cnt0`..`cnt3`  output  CNT_W each  completed output transfers per channel.

## Operation
- Each channel k has one holding register (`yk_data`) and a full flag (`y_valid[k]`).
- Channel k can load when `can_k = ~y_valid[k] | y_ready[k]`.
- `in_ready` is combinational from state, `in_sel`, `bcast`, `y_ready`; it never depends on `in_valid`:
  - `bcast`=0: `in_ready = can_{in_sel}`.
  - `bcast`=1: `in_ready = can_0 & can_1 & can_2 & can_3` (all-or-nothing).
- Input accept = `in_valid & in_ready`. On accept: target channel(s) load `in_data`, set `y_valid`.
- Output transfer on channel k = `y_valid[k] & y_ready[k]`. Clears `y_valid[k]` unless the same channel loads in that cycle; increments `cntk`.
- Non-target channels are unaffected by an accept.
- `yk_data` changes only on a load; it holds its value while `y_valid[k]` and not `y_ready[k]`, and retains the last word after draining.
- Counters are modulo 2^CNT_W: at all-ones a transfer wraps the counter to 0.
- `in_sel`, `bcast`, `in_data` are don't-care when `in_valid`=0.

## Timing
- Reset (`rst_n`=0, asynchronous): `y_valid`=4'b0000, `y0_data`..`y3_data`=0, `cnt0`..`cnt3`=0. With all channels empty, `in_ready`=1 during and after reset.
- Reset mid-operation discards all held words; no counter update for discarded words.
- Latency: word accepted at edge N is visible on `yk_data` with `y_valid[k]`=1 after edge N.
- Throughput: 1 word/cycle per channel while its `y_ready` is held high (drain and load at the same edge).
- Simultaneous drain and load on channel k at one edge: new word loaded, `y_valid[k]` stays 1, `cntk` increments once.
- Transfers on several channels at one edge: each counter increments independently.
- Broadcast with any channel full and not ready: `in_ready`=0, no channel loads; word remains upstream.
- Counter value is visible the cycle after the transfer edge.

## Test plan
- Reset then unicast: `in_valid`=1, `in_data`=8'hA5, `in_sel`=2, `y_ready`=4'b1111 -> after one edge `y2_data`=A5, `y_valid`=4'b0100; next edge `cnt2`=1, `y_valid`=0.
- Backpressure: fill channel 1 with 8'h11, hold `y_ready[1]`=0, offer 8'h22 to channel 1 -> `in_ready`=0, `y1_data` stays 11; offer 8'h33 to channel 0 -> accepted, `y0_data`=33.
- Streaming: `y_ready[3]`=1, 4 consecutive words 1,2,3,4 to channel 3 -> `in_ready` stays 1, `y3_data` shows 1..4 on successive cycles, `cnt3`=4.
- Broadcast: `bcast`=1, `in_data`=8'h5A, all channels empty -> all four `yk_data`=5A, `y_valid`=4'b1111; repeat with `y_ready`=4'b1011 and channels full -> `in_ready`=0, no change.
- Counter wrap: CNT_W=8, 256 transfers on channel 0 -> `cnt0`=0 after the 256th.
- Async reset mid-stream: assert `rst_n`=0 between edges with `y_valid`=4'b0110 -> outputs clear immediately; `in_ready`=1.
